// File: rtl/mul_sched_pkg.sv
// Shared types and defaults for the mul_sched round-robin multiplier scheduler.
package mul_sched_pkg;

  localparam int W_DEF    = 16;
  localparam int NREQ_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADA = 3'd1,
    LOADB = 3'd2,
    RUN   = 3'd3,
    RESP  = 3'd4
  } state_e;

  // Requester ID width; at least one bit even for small NREQ.
  function automatic int idWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mul_sched_if.sv
// Requester, response and datapath-control bundle for mul_sched.
interface mul_sched_if #(
  parameter int NREQ = mul_sched_pkg::NREQ_DEF,
  parameter int W    = mul_sched_pkg::W_DEF
);
  localparam int IDW = mul_sched_pkg::idWidth(NREQ);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              resp_valid;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_product;
  logic              lda;
  logic              ldb;
  logic              ldp;
  logic              clrp;
  logic              decb;
  logic [W-1:0]      data_in;
  logic              eqz;
  logic [W-1:0]      product;

  modport slave (
    input  req, a_in, b_in, eqz, product,
    output gnt, busy, resp_valid, resp_id, resp_product,
           lda, ldb, ldp, clrp, decb, data_in
  );

  modport master (
    output req, a_in, b_in, eqz, product,
    input  gnt, busy, resp_valid, resp_id, resp_product,
           lda, ldb, ldp, clrp, decb, data_in
  );

endinterface

// File: rtl/mul_sched_rr_arbiter.sv
// Round-robin picker: first requester at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  always_comb begin
    int k;
    k     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    if (en_i) begin
      for (int off = 0; off < NREQ; off++) begin
        k = (int'(ptr_i) + off) % NREQ;
        if (!any_o && req_i[k]) begin
          any_o    = 1'b1;
          gnt_o[k] = 1'b1;
          idx_o    = IDW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/mul_sched.sv
// Round-robin scheduler/sequencer sharing one repeated-addition multiplier.
// Optional MUL_SCHED_OPSWAP_EN puts the smaller operand in the B counter.
module mul_sched
  import mul_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input logic       clk,
  input logic       rst,
  mul_sched_if.slave bus
);

  localparam int IDW = idWidth(NREQ);

  state_e          state_q;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    prod_q;
  logic [W-1:0]    dataIn_q;
  logic [IDW-1:0]  respId_q;
  logic            lda_q, ldb_q, clrp_q, respValid_q;

  logic [NREQ-1:0] winGnt;
  logic [IDW-1:0]  winIdx;
  logic            winAny;
  logic [W-1:0]    selA, selB, capA_d, capB_d;

  // Arbitration is only live in IDLE and is suppressed while reset is held.
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .en_i  ((state_q == IDLE) && !rst),
    .gnt_o (winGnt),
    .idx_o (winIdx),
    .any_o (winAny)
  );

  assign selA  = bus.a_in[int'(winIdx)*W +: W];
  assign selB  = bus.b_in[int'(winIdx)*W +: W];
  assign ptr_d = (int'(winIdx) == NREQ-1) ? '0 : winIdx + IDW'(1);

`ifdef MUL_SCHED_OPSWAP_EN
  // Smaller operand drives the counter, shortening RUN without changing the product.
  assign capA_d = (selA >= selB) ? selA : selB;
  assign capB_d = (selA >= selB) ? selB : selA;
`else
  assign capA_d = selA;
  assign capB_d = selB;
`endif

  // Outputs for each state are registered on the transition into that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      dataIn_q    <= '0;
      respId_q    <= '0;
      lda_q       <= 1'b0;
      ldb_q       <= 1'b0;
      clrp_q      <= 1'b0;
      respValid_q <= 1'b0;
    end else begin
      lda_q       <= 1'b0;
      ldb_q       <= 1'b0;
      clrp_q      <= 1'b0;
      respValid_q <= 1'b0;
      dataIn_q    <= '0;
      respId_q    <= '0;
      case (state_q)
        IDLE: begin
          if (winAny) begin
            b_q      <= capB_d;
            id_q     <= winIdx;
            ptr_q    <= ptr_d;
            lda_q    <= 1'b1;
            dataIn_q <= capA_d;
            state_q  <= LOADA;
          end
        end
        LOADA: begin
          ldb_q    <= 1'b1;
          clrp_q   <= 1'b1;
          dataIn_q <= b_q;
          state_q  <= LOADB;
        end
        LOADB: state_q <= RUN;
        RUN: begin
          if (bus.eqz) begin
            prod_q      <= bus.product;
            respValid_q <= 1'b1;
            respId_q    <= id_q;
            state_q     <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt          = winGnt;
  assign bus.busy         = (state_q != IDLE) || winAny;
  assign bus.resp_valid   = respValid_q;
  assign bus.resp_id      = respId_q;
  assign bus.resp_product = prod_q;
  assign bus.lda          = lda_q;
  assign bus.ldb          = ldb_q;
  assign bus.clrp         = clrp_q;
  assign bus.data_in      = dataIn_q;
  assign bus.ldp          = (state_q == RUN) && !bus.eqz;
  assign bus.decb         = (state_q == RUN) && !bus.eqz;

endmodule

// File: doc/mul_sched.md
# mul_sched

Round-robin scheduler and sequencer that shares one repeated-addition multiplier datapath among NREQ requesters. It replaces the standalone controller FSM: it arbitrates requests and captures operands, then drives the datapath's control strobes and shared data bus. It returns each product tagged with the requester ID. It sits between the requester ports and the `mul` datapath, using `eqz` and `product` as its only feedback.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 16, operand/product width; must match the datapath
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester request; held high with operands stable until granted
- a_in  in  NREQ*W  flattened A operands; slot i = bits [i*W +: W]
- b_in  in  NREQ*W  flattened B operands; same slotting
- gnt  out  NREQ  one-hot, one-cycle grant pulse; operands captured that cycle
- busy  out  1  high from the grant cycle through the RESP cycle
- resp_valid  out  1  one-cycle pulse; product is available
- resp_id  out  $clog2(NREQ)  index of the requester being answered
- resp_product  out  W  product, truncated modulo 2^W
- lda, ldb, ldp, clrp, decb  out  1 each  datapath control strobes
- data_in  out  W  shared datapath bus
- eqz  in  1  datapath comparator flag; combinational on the B counter
- product  in  W  datapath P register

## Operation
- Reset values:
  - all outputs are 0
  - the round-robin pointer is 0
  - the state is IDLE
  - captured operands and ID are 0
- States: IDLE → LOADA → LOADB → RUN → RESP → IDLE.
- IDLE:
  - If any req is high, grant the first requester at or after the pointer, wrapping around.
  - Pulse `gnt[i]`, capture `a_in[i]`, `b_in[i]` and i, then set the pointer to (i+1) mod NREQ.
  - Go to LOADA.
  - With no req high, stay in IDLE with all strobes 0.
- LOADA: `lda`=1, `data_in`=captured A.
- LOADB: `ldb`=1, `clrp`=1, `data_in`=captured B.
- RUN:
  - `ldp` = `decb` = !eqz.
  - When `eqz`=1, assert no strobes, load `resp_product` from `product`, and go to RESP.
- RESP:
  - `resp_valid`=1 and `resp_id`=captured ID.
  - `resp_product` holds until the next response.
- `data_in` is 0 outside LOADA and LOADB. At most one of lda/ldb is high in any cycle.
- Requests arriving while busy stay pending. A req dropped before grant is never served.
- Zero operands:
  - B=0: RUN lasts one cycle and the product is 0.
  - A=0: RUN lasts B+1 cycles and the product is 0.
- Reset mid-operation aborts the operation immediately: no response is issued and the in-flight request is lost.

## Timing
- Grant at cycle T:
  - LOADA at T+1
  - LOADB at T+2
  - RUN at T+3 .. T+3+C, where C is the counter operand
  - RESP at T+4+C
- Latency from grant to `resp_valid` is C+4 cycles.
- The earliest next grant is the cycle after RESP (T+5+C); one idle cycle always separates jobs.
- `gnt` is combinational on `req` and the pointer in IDLE. All other outputs are registered or decoded from state only, apart from `ldp`/`decb`, which also depend on `eqz`.

## Configuration
- MUL_SCHED_OPSWAP_EN defined:
  - At capture, the larger operand goes to A and the smaller to B (the counter), so C = min(A,B).
  - The product is unchanged; latency becomes min(A,B)+4.
- Undefined: C = B exactly as captured, with no comparison logic.

## Structure
- Package `mul_sched_pkg`:
  - state enum (IDLE, LOADA, LOADB, RUN, RESP)
  - default W and NREQ localparams
  - ID-width function
- One sub-module, `rr_arbiter`:
  - inputs: req, pointer, enable
  - outputs: one-hot grant, winner index
  - pointer update is kept in the parent

## Test plan
- Reset released with req=0: all outputs 0 and state IDLE for 10 cycles; then req[0] with A=3, B=4 → gnt[0] pulse, resp_valid 8 cycles later with product 12 and resp_id 0.
- req[0..3] all high, each with A=2, B=1 → grants in order 0,1,2,3, each response product 2, each job 6 cycles apart.
- Pointer at 2 after serving requester 1, then req[0] and req[3] simultaneous → requester 3 is granted first, then requester 0.
- B=0, A=500 → RUN lasts one cycle with no ldp/decb, product 0 at latency 4; A=300, B=300 → product 90000 mod 65536 = 24464.
- rst asserted during RUN of a job with B=10 → outputs 0 immediately, no resp_valid; a following req[1] with A=5, B=5 → product 25, resp_id 1.
- MUL_SCHED_OPSWAP_EN defined, A=2, B=1000 → product 2000, resp_valid 6 cycles after gnt; without the macro the latency is 1004.
